frame_windower: RTL and testbench

//  Parametrised successor framer: buffers a free-running sample stream in a circular RAM.

---
 rtl/frame_windower.sv | 165 ++++++++++++++++
 tb/tb_frame_windower.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_windower.sv
// Circular-RAM framer: fixed-length, optionally overlapped or skipped frames
// streamed out on valid/ready, with ADC power hints for the sample source.
module frame_windower #(
    parameter int DATA_W    = 8,
    parameter int MAX_FRAME = 256,
    parameter int PTR_W     = $clog2(MAX_FRAME) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [3:0]        cfg_frame_log2,
    input  logic [1:0]        cfg_overlap,
    input  logic [6:0]        cfg_skip,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_first,
    output logic              m_last,
    output logic              overrun,
    output logic [15:0]       drop_count,
    output logic              adc_power_on,
    output logic              adc_data_required
);
    localparam int AW = PTR_W - 1;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

    state_t            state, state_nx;
    logic              run;
    logic [3:0]        log2_q;
    logic [1:0]        ovl_q;
    logic [6:0]        skip_q;
    logic [6:0]        fcnt;
    logic [AW-1:0]     scnt;
    logic [AW-1:0]     idx;
    logic [AW-1:0]     nm1;
    logic [AW-1:0]     rd_addr;
    logic [PTR_W-1:0]  wr, base;
    logic [PTR_W-1:0]  n_len, hop, occ, base_rel, occ_rel;
    logic              overlap, kept, full, rel, wr_en, drop, rd_en;
    logic [DATA_W-1:0] mem [MAX_FRAME];

    function automatic logic [3:0] clamp_log2(input logic [3:0] v);
        if (v < 4'd4) return 4'd4;
        if (v > 4'(AW)) return 4'(AW);
        return v;
    endfunction

    always_comb begin
        n_len = PTR_W'(1) << log2_q;
        unique case (ovl_q)
            2'd1:    hop = n_len >> 1;
            2'd2:    hop = n_len >> 2;
            default: hop = n_len;
        endcase
    end

    assign nm1      = AW'(n_len - 1'b1);
    assign overlap  = (ovl_q == 2'd1) || (ovl_q == 2'd2);
    assign kept     = overlap || (fcnt == 7'd0);
    assign occ      = wr - base;
    assign full     = (occ == PTR_W'(MAX_FRAME));
    assign base_rel = base + hop;
    assign occ_rel  = wr - base_rel;

    assign m_valid = (state == STREAM);
    assign m_first = m_valid && (idx == '0);
    assign m_last  = m_valid && (idx == nm1);
    assign rel     = m_last && m_ready;

    // A release in the same cycle frees the slot the incoming sample needs.
    assign wr_en = enable && in_valid && kept && (!full || rel);
    assign drop  = enable && in_valid && kept && full && !rel;

    assign rd_en   = (state == LOAD) || (m_valid && m_ready && !m_last);
    assign rd_addr = base[AW-1:0] + ((state == LOAD) ? '0 : idx + 1'b1);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (occ >= n_len) state_nx = LOAD;
            LOAD:    state_nx = STREAM;
            STREAM:  if (rel) state_nx = (occ_rel >= n_len) ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
        if (!enable) state_nx = IDLE;
    end

    always_comb begin
        adc_power_on      = 1'b0;
        adc_data_required = 1'b0;
        if (run && enable) begin
            if (overlap || skip_q <= 7'd1) begin
                adc_power_on      = 1'b1;
                adc_data_required = 1'b1;
            end else begin
                adc_data_required = (fcnt == 7'd0);
                adc_power_on      = (fcnt == 7'd0) || (fcnt == skip_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            run        <= 1'b0;
            log2_q     <= 4'd4;
            ovl_q      <= 2'd0;
            skip_q     <= 7'd0;
            fcnt       <= 7'd0;
            scnt       <= '0;
            idx        <= '0;
            wr         <= '0;
            base       <= '0;
            overrun    <= 1'b0;
            drop_count <= 16'd0;
        end else begin
            run   <= enable;
            state <= state_nx;
            if (!enable) begin
                log2_q <= clamp_log2(cfg_frame_log2);
                ovl_q  <= cfg_overlap;
                skip_q <= cfg_skip;
                fcnt   <= 7'd0;
                scnt   <= '0;
                idx    <= '0;
                wr     <= '0;
                base   <= '0;
            end else begin
                if (!run) begin
                    overrun    <= 1'b0;
                    drop_count <= 16'd0;
                end else if (drop) begin
                    overrun <= 1'b1;
                    if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                end
                if (wr_en) wr <= wr + 1'b1;
                if (rel) base <= base_rel;
                // Input frame position advances on every sample, kept or not.
                if (in_valid) begin
                    if (scnt == nm1) begin
                        scnt <= '0;
                        fcnt <= (overlap || fcnt >= skip_q) ? 7'd0 : fcnt + 7'd1;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                if (state == LOAD) idx <= '0;
                else if (m_valid && m_ready && !m_last) idx <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr[AW-1:0]] <= in_data;
    end

    // Registered read doubles as the output holding register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_data <= '0;
        else if (rd_en) m_data <= mem[rd_addr];
    end
endmodule

// File: tb/tb_frame_windower.sv
// Directed bench for frame_windower with an output scoreboard.
module tb_frame_windower;
    typedef logic [9:0] ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, enable, in_valid, m_ready;
    logic [3:0]  cfg_frame_log2;
    logic [1:0]  cfg_overlap;
    logic [6:0]  cfg_skip;
    logic [7:0]  in_data;
    logic        m_valid, m_first, m_last, overrun;
    logic [7:0]  m_data;
    logic [15:0] drop_count;
    logic        adc_power_on, adc_data_required;

    logic        b_enable, b_ready;
    logic        b_valid, b_first, b_last, b_overrun, b_pwr, b_req;
    logic [7:0]  b_data;
    logic [15:0] b_drops;

    frame_windower dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .cfg_frame_log2(cfg_frame_log2), .cfg_overlap(cfg_overlap),
        .cfg_skip(cfg_skip), .in_valid(in_valid), .in_data(in_data),
        .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data),
        .m_first(m_first), .m_last(m_last), .overrun(overrun),
        .drop_count(drop_count), .adc_power_on(adc_power_on),
        .adc_data_required(adc_data_required)
    );

    frame_windower #(.MAX_FRAME(32)) dut_small (
        .clk(clk), .reset_n(reset_n), .enable(b_enable),
        .cfg_frame_log2(cfg_frame_log2), .cfg_overlap(cfg_overlap),
        .cfg_skip(cfg_skip), .in_valid(in_valid), .in_data(in_data),
        .m_ready(b_ready), .m_valid(b_valid), .m_data(b_data),
        .m_first(b_first), .m_last(b_last), .overrun(b_overrun),
        .drop_count(b_drops), .adc_power_on(b_pwr),
        .adc_data_required(b_req)
    );

    int   n_cmp = 0, n_bad = 0, cyc = 0, rise_cyc = -1;
    ent_t exp_q[$], q_b[$];
    bit   mon_on = 0, hold_a = 0, hold_b = 0, rnd_ready = 0;
    ent_t held_a, held_b;

    logic [7:0] mdl[$];
    int mbase, mn, mhop, mk, scnt_m, fcnt_m;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_on) begin
            if (hold_a) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_bus", {m_data, m_first, m_last}, held_a);
            end
            if (m_valid && rise_cyc < 0) rise_cyc = cyc;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("extra_out", m_valid, 0);
                else chk("out", {m_data, m_first, m_last}, exp_q.pop_front());
            end
            hold_a = m_valid && !m_ready;
            held_a = {m_data, m_first, m_last};
        end else begin
            hold_a = 0;
        end
    end

    always @(negedge clk) begin
        if (hold_b) begin
            chk("hold_valid_s", b_valid, 1);
            chk("hold_bus_s", {b_data, b_first, b_last}, held_b);
        end
        if (b_valid && b_ready) begin
            if (q_b.size() == 0) chk("extra_out_s", b_valid, 0);
            else chk("out_s", {b_data, b_first, b_last}, q_b.pop_front());
        end
        hold_b = b_valid && !b_ready;
        held_b = {b_data, b_first, b_last};
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic model_reset(input int lg, input int ovl, input int k);
        mdl.delete();
        mbase  = 0;
        mn     = 1 << lg;
        mhop   = (ovl == 1) ? mn / 2 : (ovl == 2) ? mn / 4 : mn;
        mk     = (ovl == 1 || ovl == 2) ? 0 : k;
        scnt_m = 0;
        fcnt_m = 0;
    endtask

    task automatic configure(input int lg, input int ovl, input int k);
        enable = 0;
        in_valid = 0;
        cfg_frame_log2 = 4'(lg);
        cfg_overlap = 2'(ovl);
        cfg_skip = 7'(k);
        repeat (2) step();
        model_reset(lg, ovl, k);
        enable = 1;
        repeat (2) step();
    endtask

    task automatic drive(input logic [7:0] d);
        in_valid = 1;
        in_data = d;
        if (fcnt_m == 0) begin
            mdl.push_back(d);
            while (mdl.size() >= mbase + mn) begin
                for (int j = 0; j < mn; j++)
                    exp_q.push_back(ent_t'({mdl[mbase+j], j == 0, j == mn - 1}));
                mbase += mhop;
            end
        end
        scnt_m++;
        if (scnt_m == mn) begin
            scnt_m = 0;
            fcnt_m = (fcnt_m >= mk) ? 0 : fcnt_m + 1;
        end
        step();
        in_valid = 0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < budget) begin
            step();
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        int c15, n;
        reset_n = 0;
        enable = 1;
        b_enable = 0;
        b_ready = 0;
        m_ready = 1;
        in_valid = 0;
        in_data = 8'h5A;
        cfg_frame_log2 = 4'd4;
        cfg_overlap = 2'd0;
        cfg_skip = 7'd0;
        #12;
        chk("rst_state", {m_valid, m_first, m_last, m_data, overrun,
                          drop_count, adc_power_on, adc_data_required}, 0);
        enable = 0;
        reset_n = 1;
        mon_on = 1;
        step();

        // 1: plain frames, latency
        configure(4, 0, 0);
        rise_cyc = -1;
        c15 = 0;
        for (int i = 0; i < 64; i++) begin
            drive(8'(i));
            if (i == 15) c15 = cyc;
        end
        drain("drain_t1", 200);
        chk("latency", rise_cyc - c15, 2);

        // 2: 50% overlap
        configure(4, 1, 0);
        for (int i = 0; i < 48; i++) drive(8'(i));
        drain("drain_t2", 200);

        // 3: skip 3 with power hints
        configure(4, 0, 3);
        for (int i = 0; i < 128; i++) begin
            chk("hint_req", adc_data_required,
                (i < 16) || (i >= 64 && i < 80));
            chk("hint_pwr", adc_power_on,
                (i < 16) || (i >= 48 && i < 80) || (i >= 112));
            drive(8'(i));
        end
        drain("drain_t3", 200);

        // 4: overflow on the 32-deep instance
        enable = 0;
        cfg_frame_log2 = 4'd4;
        cfg_overlap = 2'd0;
        cfg_skip = 7'd0;
        repeat (2) step();
        b_enable = 1;
        repeat (2) step();
        for (int i = 0; i < 40; i++) begin
            in_valid = 1;
            in_data = 8'(i);
            if (i < 32) q_b.push_back(ent_t'({8'(i), i % 16 == 0, i % 16 == 15}));
            step();
        end
        in_valid = 0;
        step();
        chk("ovr_small", b_overrun, 1);
        chk("drops_small", b_drops, 8);
        chk("hints_small", {b_pwr, b_req}, 2'b11);
        b_ready = 1;
        n = 0;
        while ((q_b.size() != 0 || b_valid) && n < 100) begin
            step();
            n++;
        end
        chk("drain_t4", q_b.size(), 0);
        b_enable = 0;

        // 5: overlap with random backpressure
        configure(4, 1, 0);
        rnd_ready = 1;
        for (int i = 0; i < 48; i++) drive(8'(i));
        drain("drain_t5", 600);
        rnd_ready = 0;
        m_ready = 1;

        // 6: flush mid-frame, re-enable clears overrun
        configure(4, 0, 0);
        m_ready = 0;
        for (int i = 0; i < 260; i++) begin
            in_valid = 1;
            in_data = 8'(i);
            if (i < 16) exp_q.push_back(ent_t'({8'(i), i == 0, i == 15}));
            step();
        end
        in_valid = 0;
        step();
        chk("ovr_big", overrun, 1);
        chk("drops_big", drop_count, 4);
        m_ready = 1;
        repeat (5) step();
        chk("mid_frame", m_valid, 1);
        enable = 0;
        step();
        chk("flush_valid", m_valid, 0);
        chk("ovr_hold", overrun, 1);
        chk("drops_hold", drop_count, 4);
        exp_q.delete();
        step();
        enable = 1;
        step();
        chk("ovr_clear", overrun, 0);
        chk("drops_clear", drop_count, 0);
        model_reset(4, 0, 0);
        for (int i = 0; i < 16; i++) drive(8'(200 + i));
        drain("drain_t6", 100);

        // async reset while streaming
        for (int i = 0; i < 16; i++) drive(8'(50 + i));
        n = 0;
        while (!m_valid && n < 10) begin
            step();
            n++;
        end
        chk("stream_before_rst", m_valid, 1);
        mon_on = 0;
        exp_q.delete();
        #2 reset_n = 0;
        #1;
        chk("rst_async", {m_valid, m_first, m_last, m_data, overrun,
                          drop_count, adc_power_on, adc_data_required}, 0);
        #10 reset_n = 1;
        enable = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
